led_matrix_scanner: RTL and testbench

Parametrised, time-multiplexed LED matrix scanner with a double-buffered frame store. It replaces single-LED select drivers: the position logic writes whole row bitmaps into a back buffer and requests a swap. The block scans the front buffer one row at a time with a dead-time blanking gap between rows to prevent ghosting. It sits between the position/display logic and the matrix row/column pins.

---
 rtl/led_matrix_scanner.sv | 156 +++++++++++++++
 tb/tb_led_matrix_scanner.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: row-multiplexed LED matrix driver with a ping-pong
// frame store, blanking dead time between rows and frame-boundary swap.
module led_matrix_scanner #(
   parameter int ROWS           = 8,
   parameter int COLS           = 8,
   parameter int DWELL          = 1000,
   parameter int BLANK          = 16,
   parameter int ROW_ACTIVE_LOW = 1,
   parameter int COL_ACTIVE_LOW = 0,
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            wr_en,
   input  logic [RW-1:0]   wr_row,
   input  logic [COLS-1:0] wr_data,
   input  logic            swap_req,
   output logic            swap_done,
   output logic            frame_start,
   output logic [ROWS-1:0] row_out,
   output logic [COLS-1:0] col_out
);

   localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

   localparam logic [CW-1:0] DWELL_LD = CW'(DWELL - 1);
   localparam logic [CW-1:0] BLANK_LD = CW'(BLANK - 1);
   localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
   localparam logic [RW:0]   ROWS_W   = (RW + 1)'(ROWS);

   localparam logic RI = (ROW_ACTIVE_LOW != 0);
   localparam logic CI = (COL_ACTIVE_LOW != 0);
   localparam logic [ROWS-1:0] ROW_OFF = {ROWS{RI}};
   localparam logic [COLS-1:0] COL_OFF = {COLS{CI}};

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_DRIVE = 1'b1
   } state_e;

   state_e                      state_q, state_d;
   logic [RW-1:0]               row_q, row_d;
   logic [CW-1:0]               cnt_q, cnt_d;
   logic                        sel_q, sel_d;
   logic                        pend_q, pend_d;
   logic [ROWS-1:0][COLS-1:0]   bank_a_q, bank_a_d;
   logic [ROWS-1:0][COLS-1:0]   bank_b_q, bank_b_d;
   logic [ROWS-1:0]             row_out_q, row_out_d;
   logic [COLS-1:0]             col_out_q, col_out_d;
   logic                        swap_done_q, swap_done_d;
   logic                        frame_start_q, frame_start_d;
   logic [ROWS-1:0]             row_hot;
   logic [COLS-1:0]             front_row;
   logic                        wr_ok;

   // scan sequencing: dwell/blank timing, row advance, frame-boundary swap
   always_comb begin
      state_d       = state_q;
      row_d         = row_q;
      cnt_d         = cnt_q - 1'b1;
      sel_d         = sel_q;
      pend_d        = pend_q | swap_req;
      swap_done_d   = 1'b0;
      frame_start_d = 1'b0;
      if (cnt_q == '0) begin
         unique case (state_q)
            ST_BLANK: begin
               state_d = ST_DRIVE;
               cnt_d   = DWELL_LD;
            end
            ST_DRIVE: begin
               state_d = ST_BLANK;
               cnt_d   = BLANK_LD;
               if (row_q == LAST_ROW) begin
                  row_d         = '0;
                  frame_start_d = 1'b1;
                  if (pend_q) begin
                     sel_d       = ~sel_q;
                     pend_d      = swap_req;
                     swap_done_d = 1'b1;
                  end
               end else begin
                  row_d = row_q + 1'b1;
               end
            end
            default: begin
               state_d = ST_BLANK;
               cnt_d   = BLANK_LD;
            end
         endcase
      end
   end

   // host writes always target the bank that is currently in the back
   always_comb begin
      bank_a_d = bank_a_q;
      bank_b_d = bank_b_q;
      wr_ok    = wr_en && ({1'b0, wr_row} < ROWS_W);
      if (wr_ok) begin
         if (sel_q) begin
            bank_a_d[wr_row] = wr_data;
         end else begin
            bank_b_d[wr_row] = wr_data;
         end
      end
   end

   // pin levels follow the next state so they switch with the state itself
   always_comb begin
      row_hot        = '0;
      row_hot[row_d] = 1'b1;
      front_row      = sel_d ? bank_b_q[row_d] : bank_a_q[row_d];
      row_out_d      = ROW_OFF;
      col_out_d      = COL_OFF;
      if (state_d == ST_DRIVE) begin
         row_out_d = RI ? ~row_hot : row_hot;
         col_out_d = CI ? ~front_row : front_row;
      end
   end

   // state, frame store and registered pins
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_BLANK;
         row_q         <= '0;
         cnt_q         <= BLANK_LD;
         sel_q         <= 1'b0;
         pend_q        <= 1'b0;
         bank_a_q      <= '0;
         bank_b_q      <= '0;
         row_out_q     <= ROW_OFF;
         col_out_q     <= COL_OFF;
         swap_done_q   <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         row_q         <= row_d;
         cnt_q         <= cnt_d;
         sel_q         <= sel_d;
         pend_q        <= pend_d;
         bank_a_q      <= bank_a_d;
         bank_b_q      <= bank_b_d;
         row_out_q     <= row_out_d;
         col_out_q     <= col_out_d;
         swap_done_q   <= swap_done_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign row_out     = row_out_q;
   assign col_out     = col_out_q;
   assign swap_done   = swap_done_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// tb_led_matrix_scanner: frame-position model plus directed scenarios
// for the LED matrix scanner.
module tb_led_matrix_scanner;

   localparam int R  = 8;
   localparam int BL = 2;
   localparam int DW = 4;
   localparam int RP = BL + DW;
   localparam int F  = R * RP;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       wr_en = 1'b0;
   logic [2:0] wr_row = '0;
   logic [7:0] wr_data = '0;
   logic       swap_req = 1'b0;
   logic       swap_done, frame_start;
   logic [7:0] row_out, col_out;

   logic       wr_en2 = 1'b0;
   logic [2:0] wr_row2 = '0;
   logic [7:0] wr_data2 = '0;
   logic       swap_req2 = 1'b0;
   logic       swap_done2, frame_start2;
   logic [4:0] row_out2;
   logic [7:0] col_out2;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   led_matrix_scanner #(
      .ROWS(8), .COLS(8), .DWELL(DW), .BLANK(BL),
      .ROW_ACTIVE_LOW(1), .COL_ACTIVE_LOW(0)
   ) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_row(wr_row),
      .wr_data(wr_data), .swap_req(swap_req), .swap_done(swap_done),
      .frame_start(frame_start), .row_out(row_out), .col_out(col_out)
   );

   led_matrix_scanner #(
      .ROWS(5), .COLS(8), .DWELL(DW), .BLANK(BL),
      .ROW_ACTIVE_LOW(1), .COL_ACTIVE_LOW(0)
   ) dut5 (
      .clk(clk), .reset(reset), .wr_en(wr_en2), .wr_row(wr_row2),
      .wr_data(wr_data2), .swap_req(swap_req2), .swap_done(swap_done2),
      .frame_start(frame_start2), .row_out(row_out2), .col_out(col_out2)
   );

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // model: frame contents as two plain arrays, position from cycle count
   logic [7:0] m_front [R];
   logic [7:0] m_back  [R];
   logic [7:0] m_tmp;
   bit         m_pend;
   bit         m_sd;
   int         k;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < R; i++) begin
            m_front[i] = '0;
            m_back[i]  = '0;
         end
         m_pend = 0;
         m_sd   = 0;
         k      = 0;
      end else begin
         if (wr_en && (int'(wr_row) < R)) m_back[wr_row] = wr_data;
         m_sd = 0;
         if (((k + 1) % F == 0) && m_pend) begin
            for (int i = 0; i < R; i++) begin
               m_tmp      = m_front[i];
               m_front[i] = m_back[i];
               m_back[i]  = m_tmp;
            end
            m_sd   = 1;
            m_pend = swap_req;
         end else begin
            m_pend = m_pend | swap_req;
         end
         k++;
      end
   end

   // every-cycle comparison against the model
   always @(negedge clk) begin
      int p, r, q;
      logic [7:0] er, ec;
      if (reset) begin
         check("rst_row_out", row_out, 8'hFF);
         check("rst_col_out", col_out, 8'h00);
         check("rst_swap_done", swap_done, 1'b0);
         check("rst_frame_start", frame_start, 1'b0);
      end else begin
         p = k % F;
         r = p / RP;
         q = p % RP;
         if (q < BL) begin
            er = 8'hFF;
            ec = 8'h00;
         end else begin
            er = ~(8'h01 << r);
            ec = m_front[r];
         end
         check("row_out", row_out, er);
         check("col_out", col_out, ec);
         check("swap_done", swap_done, m_sd);
         check("frame_start", frame_start, (k > 0) && (p == 0));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_row(input logic [7:0] pat, input string nm);
      int n = 0;
      while (row_out !== pat && n < 200) begin
         tick();
         n++;
      end
      check(nm, row_out, pat);
   endtask

   task automatic wait_swap(input string nm, output int lat);
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!swap_done && lat < 120);
      check(nm, swap_done, 1'b1);
   endtask

   task automatic wait_fs(input string nm);
      int n = 0;
      while (!frame_start && n < 120) begin
         tick();
         n++;
      end
      check(nm, frame_start, 1'b1);
   endtask

   task automatic pulse_swap();
      swap_req = 1'b1;
      tick();
      swap_req = 1'b0;
   endtask

   initial begin
      int lat, n;
      logic [7:0] exp;
      logic [4:0] seen;
      int rr;

      repeat (3) tick();
      check("in_rst_row", row_out, 8'hFF);
      check("in_rst_col", col_out, 8'h00);
      reset = 1'b0;

      for (int i = 0; i < 9; i++) begin
         exp = (i < 2) ? 8'hFF : (i < 6) ? 8'hFE : (i < 8) ? 8'hFF : 8'hFD;
         check("scan_seq", row_out, exp);
         tick();
      end

      wr_en = 1'b1; wr_row = 3'd3; wr_data = 8'hA5;
      tick();
      wr_en = 1'b0;
      pulse_swap();
      wait_swap("swap1_seen", lat);
      check("swap1_lat_le48", lat <= 48, 1'b1);
      wait_row(8'hFB, "row2_sel");
      check("row2_col", col_out, 8'h00);
      wait_row(8'hF7, "row3_sel");
      check("row3_col", col_out, 8'hA5);

      wait_fs("fs_a");
      n = 0;
      do begin
         tick();
         n++;
      end while (!frame_start && n < 120);
      check("fs_period", n, 48);

      pulse_swap();
      wait_swap("swap2_seen", lat);
      wait_row(8'hF7, "pp_row3_sel");
      check("pp_row3_col", col_out, 8'h00);

      wait_fs("fs_b");
      swap_req = 1'b1;
      tick();
      swap_req = 1'b0;
      repeat (46) tick();
      wr_en = 1'b1; wr_row = 3'd0; wr_data = 8'h3C; swap_req = 1'b1;
      tick();
      check("bnd_swap_done", swap_done, 1'b1);
      check("bnd_frame_start", frame_start, 1'b1);
      wr_en = 1'b0; swap_req = 1'b0;
      tick();
      tick();
      check("bnd_row0_sel", row_out, 8'hFE);
      check("bnd_row0_col", col_out, 8'h3C);
      n = 0;
      repeat (45) begin
         tick();
         if (swap_done) n++;
      end
      check("bnd_single_pulse", n, 0);
      tick();
      check("bnd_late_req_swap", swap_done, 1'b1);

      wr_en = 1'b1; wr_row = 3'd5; wr_data = 8'h81;
      tick();
      wr_en = 1'b0;
      pulse_swap();
      wait_swap("swap3_seen", lat);
      wait_row(8'hDF, "row5_sel");
      check("row5_col", col_out, 8'h81);
      reset = 1'b1;
      #1;
      check("mid_rst_row", row_out, 8'hFF);
      check("mid_rst_col", col_out, 8'h00);
      tick();
      tick();
      reset = 1'b0;
      check("post_rst_row", row_out, 8'hFF);
      tick();
      tick();
      check("post_rst_row0", row_out, 8'hFE);
      wait_row(8'hDF, "post_rst_row5_sel");
      check("post_rst_row5_col", col_out, 8'h00);
      pulse_swap();
      wait_swap("swap4_seen", lat);
      wait_row(8'hFE, "post_swap_row0_sel");
      check("post_swap_row0_col", col_out, 8'h00);
      wait_row(8'hDF, "post_swap_row5_sel");
      check("post_swap_row5_col", col_out, 8'h00);

      for (int r = 0; r < 5; r++) begin
         wr_en2 = 1'b1; wr_row2 = 3'(r); wr_data2 = 8'((r + 1) * 17);
         tick();
      end
      for (int r = 5; r < 8; r++) begin
         wr_en2 = 1'b1; wr_row2 = 3'(r); wr_data2 = 8'hFF;
         tick();
      end
      wr_en2 = 1'b0;
      swap_req2 = 1'b1;
      tick();
      swap_req2 = 1'b0;
      n = 0;
      while (!swap_done2 && n < 80) begin
         tick();
         n++;
      end
      check("r5_swap_seen", swap_done2, 1'b1);
      seen = '0;
      repeat (32) begin
         if (row_out2 !== 5'h1F) begin
            rr = -1;
            for (int r = 0; r < 5; r++) if (row_out2 === ~(5'h01 << r)) rr = r;
            check("r5_row_onehot", rr >= 0, 1'b1);
            if (rr >= 0) begin
               check("r5_col", col_out2, 8'((rr + 1) * 17));
               seen[rr] = 1'b1;
            end
         end
         tick();
      end
      check("r5_all_rows_seen", seen, 5'h1F);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
